// File: rtl/mux_pkg.sv
// Shared widths and types for the 8-to-1 bit-select leaf cell.
package mux_pkg;
  localparam int unsigned NUM_IN = 8;
  localparam int unsigned SEL_W  = 3;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_IN-1:0] data_t;
endpackage

// File: rtl/mux_8to1_dec_3to8.sv
// Combinational 3-to-8 one-hot decoder used by the mux_8to1 one-hot build.
// The module exists only when MUX_8TO1_ONEHOT_EN is defined.
`ifdef MUX_8TO1_ONEHOT_EN
module dec_3to8
  import mux_pkg::*;
(
  input  logic [SEL_W-1:0]  s,
  output logic [NUM_IN-1:0] oh
);
  always_comb begin
    oh = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (s == SEL_W'(i)) oh[i] = 1'b1;
    end
  end
endmodule
`endif

// File: rtl/mux_8to1.sv
// 8-to-1 single-bit mux with same-cycle output y and registered y_q/s_q.
// Optional MUX_8TO1_ONEHOT_EN adds sel_oh/sel_oh_q and an AND-OR select path.
module mux_8to1
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] v,
  input  logic [SEL_W-1:0]  s,
  output logic              y,
  output logic              y_q,
`ifdef MUX_8TO1_ONEHOT_EN
  output logic [NUM_IN-1:0] sel_oh,
  output logic [NUM_IN-1:0] sel_oh_q,
`endif
  output logic [SEL_W-1:0]  s_q
);
  logic       w_y;
  logic       r_y_q;
  sel_t       r_s_q;

`ifdef MUX_8TO1_ONEHOT_EN
  data_t w_oh;
  data_t r_oh_q;

  dec_3to8 u_dec (
    .s  (s),
    .oh (w_oh)
  );

  assign w_y      = |(v & w_oh);
  assign sel_oh   = w_oh;
  assign sel_oh_q = r_oh_q;

  always_ff @(posedge clk) begin
    if (rst) r_oh_q <= '0;
    else     r_oh_q <= w_oh;
  end
`else
  // Plain indexed select so an X/Z select propagates X rather than a default.
  assign w_y = v[s];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q <= 1'b0;
      r_s_q <= '0;
    end else begin
      r_y_q <= w_y;
      r_s_q <= s;
    end
  end

  assign y   = w_y;
  assign y_q = r_y_q;
  assign s_q = r_s_q;
endmodule

// File: tb/tb_mux_8to1.sv
// Directed self-checking bench for mux_8to1 (covers MUX_8TO1_ONEHOT_EN when defined).
module tb_mux_8to1;
  logic       clk;
  logic       rst;
  logic [7:0] v;
  logic [2:0] s;
  logic       y;
  logic       y_q;
  logic [2:0] s_q;
`ifdef MUX_8TO1_ONEHOT_EN
  logic [7:0] sel_oh;
  logic [7:0] sel_oh_q;
`endif

  int n_vec;
  int n_bad;

  mux_8to1 dut (
    .clk      (clk),
    .rst      (rst),
    .v        (v),
    .s        (s),
    .y        (y),
    .y_q      (y_q),
`ifdef MUX_8TO1_ONEHOT_EN
    .sel_oh   (sel_oh),
    .sel_oh_q (sel_oh_q),
`endif
    .s_q      (s_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb();
    logic [7:0] exp_tab;
    exp_tab = 8'b01011100;
    v = 8'b01011100;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      #1;
      n_vec++;
      if (y !== exp_tab[i]) begin
        n_bad++;
        $display("FAIL comb_sweep s=%0d y=%b required=%b", i, y, exp_tab[i]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; v = 8'hFF; s = 3'd3;
    for (int i = 0; i < 2; i++) begin
      edge_settle();
      n_vec++;
      if (y !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_y edge=%0d y=%b required=1", i, y);
      end
    end
    n_vec++;
    if (y_q !== 1'b0 || s_q !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_regs y_q=%b s_q=%0d required y_q=0 s_q=0", y_q, s_q);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst = 1'b0; v = 8'hA5; s = 3'd0;
    edge_settle();
    n_vec++;
    if (y_q !== 1'b1 || s_q !== 3'd0) begin
      n_bad++;
      $display("FAIL latency_n1 y_q=%b s_q=%0d required y_q=1 s_q=0", y_q, s_q);
    end
    @(negedge clk);
    s = 3'd1;
    edge_settle();
    n_vec++;
    if (y_q !== 1'b0 || s_q !== 3'd1) begin
      n_bad++;
      $display("FAIL latency_n2 y_q=%b s_q=%0d required y_q=0 s_q=1", y_q, s_q);
    end
  endtask

  task automatic test_data_only();
    @(negedge clk);
    s = 3'd7; v = 8'h80;
    #1;
    n_vec++;
    if (y !== 1'b1) begin
      n_bad++;
      $display("FAIL data_y_80 y=%b required=1", y);
    end
    edge_settle();
    n_vec++;
    if (y_q !== 1'b1) begin
      n_bad++;
      $display("FAIL data_yq_80 y_q=%b required=1", y_q);
    end
    @(negedge clk);
    v = 8'h7F;
    #1;
    n_vec++;
    if (y !== 1'b0 || y_q !== 1'b1) begin
      n_bad++;
      $display("FAIL data_lag_7f y=%b y_q=%b required y=0 y_q=1", y, y_q);
    end
    edge_settle();
    n_vec++;
    if (y_q !== 1'b0 || s_q !== 3'd7) begin
      n_bad++;
      $display("FAIL data_yq_7f y_q=%b s_q=%0d required y_q=0 s_q=7", y_q, s_q);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    s = 3'd2; v = 8'h04;
    edge_settle();
    n_vec++;
    if (y_q !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_stream y_q=%b required=1", y_q);
    end
    @(negedge clk);
    rst = 1'b1;
    edge_settle();
    n_vec++;
    if (y_q !== 1'b0 || s_q !== 3'd0 || y !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset y_q=%b s_q=%0d y=%b required y_q=0 s_q=0 y=1", y_q, s_q, y);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_settle();
    n_vec++;
    if (y_q !== 1'b1 || s_q !== 3'd2) begin
      n_bad++;
      $display("FAIL mid_release y_q=%b s_q=%0d required y_q=1 s_q=2", y_q, s_q);
    end
  endtask

  task automatic test_back_to_back();
    // v=8'h3C: bits 2..5 set; registered sweep of all selects
    logic [7:0] exp_tab;
    exp_tab = 8'h3C;
    v = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = 3'(i);
      edge_settle();
      n_vec++;
      if (y_q !== exp_tab[i] || s_q !== 3'(i)) begin
        n_bad++;
        $display("FAIL b2b s=%0d y_q=%b s_q=%0d required y_q=%b s_q=%0d",
                 i, y_q, s_q, exp_tab[i], i);
      end
    end
  endtask

`ifdef MUX_8TO1_ONEHOT_EN
  task automatic test_onehot();
    @(negedge clk);
    s = 3'd5; v = 8'h20;
    #1;
    n_vec++;
    if (sel_oh !== 8'b00100000 || y !== 1'b1) begin
      n_bad++;
      $display("FAIL oh_s5 sel_oh=%b y=%b required sel_oh=00100000 y=1", sel_oh, y);
    end
    v = 8'hDF;
    #1;
    n_vec++;
    if (y !== 1'b0) begin
      n_bad++;
      $display("FAIL oh_df y=%b required=0", y);
    end
    edge_settle();
    n_vec++;
    if (sel_oh_q !== 8'b00100000) begin
      n_bad++;
      $display("FAIL oh_q sel_oh_q=%h required=20", sel_oh_q);
    end
    @(negedge clk);
    rst = 1'b1;
    edge_settle();
    n_vec++;
    if (sel_oh_q !== 8'h00) begin
      n_bad++;
      $display("FAIL oh_q_reset sel_oh_q=%h required=00", sel_oh_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    v = '0;
    s = '0;
    test_comb();
    test_reset();
    test_latency();
    test_data_only();
    test_reset_mid();
    test_back_to_back();
`ifdef MUX_8TO1_ONEHOT_EN
    test_onehot();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
